// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory byte loader.
package loader_pkg;

    // Loader control states
    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE,
        DONE
    } loader_state_t;

    // Bytes packed into one imem word
    localparam int BYTES_PER_WORD = 4;

    // Byte lane index inside a word (lane 0 = bits 7:0)
    typedef logic [1:0] lane_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte packer: collects stream bytes into a 32-bit word.
// Unfilled lanes stay zero because the buffer is cleared after every word.
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        take,
    input  logic        clear,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output lane_t       lane_cnt
);

    // Lane counter and word buffer; clear has priority over take
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word     <= '0;
            lane_cnt <= '0;
        end else if (clear) begin
            word     <= '0;
            lane_cnt <= '0;
        end else if (take) begin
            word[{lane_cnt, 3'b000} +: 8] <= byte_in;
            lane_cnt                      <= lane_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Run-time instruction memory loader: accepts a byte stream, packs it into
// 32-bit words and writes them to the imem while holding the CPU in reset.
module imem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              load_end,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic [ADDR_W:0]   word_count,
    output logic              overflow_err
);

    localparam logic [ADDR_W:0] DEPTH     = {1'b1, {ADDR_W{1'b0}}};
    localparam lane_t           LAST_LANE = lane_t'(BYTES_PER_WORD - 1);

    loader_state_t   state;
    loader_state_t   state_next;
    logic            end_pending;
    logic            end_pending_next;
    logic            take;
    logic            clear;
    lane_t           lane_cnt;
    logic [31:0]     packed_word;
    logic [ADDR_W:0] count_next;

    byte_packer u_packer (
        .clk      (clk),
        .reset    (reset),
        .take     (take),
        .clear    (clear),
        .byte_in  (byte_data),
        .word     (packed_word),
        .lane_cnt (lane_cnt)
    );

    assign mem_wdata  = packed_word;
    assign count_next = word_count + 1'b1;

    // State register and the remembered end-of-program request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            end_pending <= 1'b0;
        end else begin
            state       <= state_next;
            end_pending <= end_pending_next;
        end
    end

    // Next-state and output decode; a byte taken with load_end is packed first
    always_comb begin
        state_next       = state;
        end_pending_next = end_pending;
        byte_ready       = 1'b0;
        cpu_hold         = 1'b0;
        mem_we           = 1'b0;
        load_done        = 1'b0;
        take             = 1'b0;
        clear            = 1'b0;
        case (state)
            IDLE: begin
                if (load_start) begin
                    state_next       = LOAD;
                    end_pending_next = 1'b0;
                    clear            = 1'b1;
                end
            end
            LOAD: begin
                byte_ready = 1'b1;
                cpu_hold   = 1'b1;
                take       = byte_valid;
                if (byte_valid && (lane_cnt == LAST_LANE)) begin
                    state_next       = WRITE;
                    end_pending_next = load_end;
                end else if (load_end) begin
                    if (byte_valid || (lane_cnt != '0)) begin
                        state_next       = WRITE;
                        end_pending_next = 1'b1;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            WRITE: begin
                cpu_hold         = 1'b1;
                mem_we           = !overflow_err;
                clear            = 1'b1;
                end_pending_next = 1'b0;
                state_next       = end_pending ? DONE : LOAD;
            end
            DONE: begin
                cpu_hold   = 1'b1;
                load_done  = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Write address, word count and sticky overflow; frozen once memory is full
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr     <= '0;
            word_count   <= '0;
            overflow_err <= 1'b0;
        end else if ((state == IDLE) && load_start) begin
            mem_addr     <= '0;
            word_count   <= '0;
            overflow_err <= 1'b0;
        end else if (mem_we) begin
            mem_addr   <= mem_addr + 1'b1;
            word_count <= count_next;
            if (count_next == DEPTH) begin
                overflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: one DUT at full depth and one at
// depth 4 share the same stimulus; each is checked against a packing model.
module tb_imem_loader;

    logic       clk;
    logic       reset;
    logic       load_start;
    logic       load_end;
    logic       byte_valid;
    logic [7:0] byte_data;

    logic        byte_ready_b, mem_we_b, cpu_hold_b, load_done_b, overflow_b;
    logic [5:0]  mem_addr_b;
    logic [31:0] mem_wdata_b;
    logic [6:0]  word_count_b;

    logic        byte_ready_s, mem_we_s, cpu_hold_s, load_done_s, overflow_s;
    logic [1:0]  mem_addr_s;
    logic [31:0] mem_wdata_s;
    logic [2:0]  word_count_s;

    int compares   = 0;
    int mismatches = 0;

    logic [7:0]  sent[$];
    logic [39:0] wr_b[$];
    logic [39:0] wr_s[$];

    imem_loader #(.ADDR_W(6)) dut_big (
        .clk          (clk),
        .reset        (reset),
        .load_start   (load_start),
        .load_end     (load_end),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready_b),
        .mem_we       (mem_we_b),
        .mem_addr     (mem_addr_b),
        .mem_wdata    (mem_wdata_b),
        .cpu_hold     (cpu_hold_b),
        .load_done    (load_done_b),
        .word_count   (word_count_b),
        .overflow_err (overflow_b)
    );

    imem_loader #(.ADDR_W(2)) dut_small (
        .clk          (clk),
        .reset        (reset),
        .load_start   (load_start),
        .load_end     (load_end),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_ready   (byte_ready_s),
        .mem_we       (mem_we_s),
        .mem_addr     (mem_addr_s),
        .mem_wdata    (mem_wdata_s),
        .cpu_hold     (cpu_hold_s),
        .load_done    (load_done_s),
        .word_count   (word_count_s),
        .overflow_err (overflow_s)
    );

    // 100 MHz-style free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compares++;
        if (got !== exp) begin
            mismatches++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Capture every imem write and confirm the stream is stalled while writing
    always @(negedge clk) begin
        if (mem_we_b === 1'b1) begin
            checkOutput("ready_during_write_big", byte_ready_b, 0);
            wr_b.push_back({2'b00, mem_addr_b, mem_wdata_b});
        end
        if (mem_we_s === 1'b1) begin
            checkOutput("ready_during_write_small", byte_ready_s, 0);
            wr_s.push_back({6'b000000, mem_addr_s, mem_wdata_s});
        end
    end

    // Reference packing: word i holds bytes 4i..4i+3, little-endian, zero padded
    function automatic logic [31:0] expectedWord(input int i);
        logic [31:0] w;
        w = 32'h0;
        for (int k = 0; k < 4; k++) begin
            if (4 * i + k < sent.size()) begin
                w = w | (32'(sent[4 * i + k]) << (8 * k));
            end
        end
        return w;
    endfunction

    // Compare one DUT's writes and final status against the model
    task automatic checkWrites(input string name, input int depth, input logic [39:0] cap[$],
                               input logic [7:0] wc, input logic ovf);
        int nw;
        int written;
        nw      = (sent.size() + 3) / 4;
        written = (nw < depth) ? nw : depth;
        checkOutput({name, "_nwrites"}, cap.size(), written);
        for (int i = 0; i < cap.size() && i < written; i++) begin
            checkOutput({name, "_addr"}, cap[i][39:32], i);
            checkOutput({name, "_data"}, cap[i][31:0], expectedWord(i));
        end
        checkOutput({name, "_word_count"}, wc, written);
        checkOutput({name, "_overflow"}, ovf, (nw >= depth) ? 1 : 0);
    endtask

    // Present one byte (optionally with load_end) and hold it until accepted
    task automatic applyStimulus(input logic [7:0] b, input bit with_end, input int gap);
        int bound;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        load_end   = with_end;
        bound      = 20;
        while (!byte_ready_b && bound > 0) begin
            @(negedge clk);
            bound--;
        end
        if (bound == 0) begin
            checkOutput("byte_accept_timeout", 0, 1);
        end else begin
            checkOutput("ready_small_matches", byte_ready_s, 1);
            @(posedge clk);
            sent.push_back(b);
        end
        #1;
        byte_valid = 1'b0;
        load_end   = 1'b0;
    endtask

    // Raise load_end alone until the loader takes it
    task automatic sendEnd();
        int bound;
        @(negedge clk);
        load_end = 1'b1;
        bound    = 20;
        while (!byte_ready_b && bound > 0) begin
            @(negedge clk);
            bound--;
        end
        if (bound == 0) checkOutput("end_accept_timeout", 0, 1);
        else @(posedge clk);
        #1;
        load_end = 1'b0;
    endtask

    // One-cycle load_start pulse; used mid-load where it must be ignored
    task automatic pulseStart();
        @(negedge clk);
        load_start = 1'b1;
        @(posedge clk);
        #1;
        load_start = 1'b0;
    endtask

    // Begin a load and confirm the loader entered LOAD with cleared status
    task automatic startLoad(input bit with_end);
        @(negedge clk);
        load_start = 1'b1;
        load_end   = with_end;
        @(posedge clk);
        #1;
        load_start = 1'b0;
        load_end   = 1'b0;
        sent.delete();
        wr_b.delete();
        wr_s.delete();
        @(negedge clk);
        checkOutput("start_cpu_hold", cpu_hold_b, 1);
        checkOutput("start_byte_ready", byte_ready_b, 1);
        checkOutput("start_no_done", load_done_b, 0);
        checkOutput("start_word_count", word_count_b, 0);
        checkOutput("start_overflow_small", overflow_s, 0);
    endtask

    // End the load, wait for the done pulse, then check the results
    task automatic finishLoad(input bit end_sent);
        int bound;
        if (!end_sent) sendEnd();
        bound = 12;
        do begin
            @(negedge clk);
            bound--;
        end while (!load_done_b && bound > 0);
        checkOutput("done_pulse_seen", load_done_b, 1);
        checkOutput("done_small_seen", load_done_s, 1);
        checkOutput("hold_during_done", cpu_hold_b, 1);
        @(negedge clk);
        checkOutput("hold_released", cpu_hold_b, 0);
        checkOutput("done_one_cycle", load_done_b, 0);
        checkWrites("big", 64, wr_b, 8'(word_count_b), overflow_b);
        checkWrites("small", 4, wr_s, 8'(word_count_s), overflow_s);
    endtask

    // Every output of both instances at its reset value
    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_big_ctrl"},
                    {byte_ready_b, mem_we_b, cpu_hold_b, load_done_b, overflow_b}, 0);
        checkOutput({tag, "_big_addr"}, mem_addr_b, 0);
        checkOutput({tag, "_big_wdata"}, mem_wdata_b, 0);
        checkOutput({tag, "_big_count"}, word_count_b, 0);
        checkOutput({tag, "_small_ctrl"},
                    {byte_ready_s, mem_we_s, cpu_hold_s, load_done_s, overflow_s}, 0);
        checkOutput({tag, "_small_count"}, word_count_s, 0);
    endtask

    // Directed scenarios followed by randomized loads
    initial begin
        logic [7:0] basic_bytes[8];
        int n;
        bit end_with_last;

        reset      = 1'b1;
        load_start = 1'b0;
        load_end   = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        repeat (3) @(negedge clk);
        checkResetValues("reset");
        reset = 1'b0;

        // Basic two-word load
        basic_bytes = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        startLoad(0);
        foreach (basic_bytes[i]) applyStimulus(basic_bytes[i], 0, 0);
        finishLoad(0);
        if (wr_b.size() >= 2) begin
            checkOutput("basic_word0", wr_b[0], {8'd0, 32'h12345678});
            checkOutput("basic_word1", wr_b[1], {8'd1, 32'hDEADBEEF});
        end else begin
            checkOutput("basic_write_count", wr_b.size(), 2);
        end
        checkOutput("basic_word_count", word_count_b, 2);

        // Partial final word is zero padded
        startLoad(0);
        applyStimulus(8'hAA, 0, 0);
        applyStimulus(8'hBB, 0, 1);
        applyStimulus(8'hCC, 0, 0);
        finishLoad(0);
        if (wr_b.size() == 1) checkOutput("partial_word", wr_b[0], {8'd0, 32'h00CCBBAA});
        else checkOutput("partial_write_count", wr_b.size(), 1);
        checkOutput("partial_word_count", word_count_b, 1);

        // Overflow on the depth-4 instance: 20 bytes, only 4 writes
        startLoad(0);
        for (int i = 0; i < 20; i++) applyStimulus(8'(i + 1), 0, 0);
        finishLoad(0);
        checkOutput("ovf_small_writes", wr_s.size(), 4);
        checkOutput("ovf_small_flag", overflow_s, 1);
        checkOutput("ovf_small_count", word_count_s, 4);
        checkOutput("ovf_big_writes", wr_b.size(), 5);

        // Reset in the middle of a load aborts without writing
        startLoad(0);
        applyStimulus(8'h11, 0, 0);
        applyStimulus(8'h22, 0, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkResetValues("midreset");
        @(negedge clk);
        reset = 1'b0;
        checkOutput("midreset_no_write", wr_b.size() + wr_s.size(), 0);
        startLoad(0);
        for (int i = 0; i < 4; i++) applyStimulus(8'(8'hA0 + i), 0, 0);
        finishLoad(0);
        if (wr_b.size() > 0) checkOutput("after_reset_addr", wr_b[0][39:32], 0);

        // load_end together with the 4th byte gives one write then DONE
        startLoad(0);
        applyStimulus(8'h01, 0, 0);
        applyStimulus(8'h02, 0, 0);
        applyStimulus(8'h03, 0, 0);
        applyStimulus(8'h04, 1, 0);
        finishLoad(1);
        checkOutput("end_with_lane3_writes", wr_b.size(), 1);

        // load_start during LOAD is ignored
        startLoad(0);
        applyStimulus(8'h5A, 0, 0);
        pulseStart();
        for (int i = 0; i < 5; i++) applyStimulus(8'(8'hC0 + i), 0, 0);
        pulseStart();
        finishLoad(0);

        // load_start with load_end in IDLE enters LOAD only
        startLoad(1);
        checkOutput("start_end_idle_still_loading", {cpu_hold_b, byte_ready_b}, 2'b11);
        applyStimulus(8'h9C, 0, 0);
        applyStimulus(8'h3E, 0, 0);
        finishLoad(0);

        // Randomized loads with gaps, mixed end timing and ignored starts
        for (int load = 0; load < 15; load++) begin
            n = $urandom_range(0, 40);
            end_with_last = (n > 0) && ($urandom_range(0, 1) == 1);
            startLoad(0);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 15) == 0) pulseStart();
                applyStimulus(8'($urandom), end_with_last && (i == n - 1),
                              ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
            end
            finishLoad(end_with_last);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
        $finish;
    end

endmodule
